// File: rtl/fetch_unit.sv
// Instruction prefetch into a 2-entry queue; optional ack timeout under `FETCH_TIMEOUT_EN.
// Latency: request issued the edge after IDLE, data visible on ir the edge after mem_ack.
// Backpressure: issue stalls while the queue is full, a flush is pending or fetch_err is set.
module fetch_unit #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] pc,
  output logic            pc_inc,
  input  logic            flush,
  output logic            mem_req,
  output logic [SIZE-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [SIZE-1:0] mem_data,
  output logic [SIZE-1:0] ir,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic            fetch_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t          state;
  logic [SIZE-1:0] q0;
  logic [SIZE-1:0] q1;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic            issue;
  logic            to_hit;

  assign ir       = q0;
  assign ir_valid = (count != 2'd0);
  assign pop      = ir_valid && ir_ready;
  assign push     = (state == BUSY) && mem_ack && !flush;
  assign pc_inc   = push;
  assign issue    = (state == IDLE) && (count < 2'd2) && !flush && !fetch_err;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;

  assign to_hit = (state != IDLE) && !mem_ack && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == IDLE || mem_ack || to_hit)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + CW'(1);
      if (flush)
        fetch_err <= 1'b0;
      else if (to_hit)
        fetch_err <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state    <= BUSY;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
        BUSY: begin
          if (mem_ack || to_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Data for a flushed request is dropped; only the ack releases the bus.
          if (mem_ack || to_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Head always lives in q0 so ir needs no read mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0    <= '0;
      q1    <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0)
            q0 <= mem_data;
          else
            q1 <= mem_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q0 <= mem_data;
          end else begin
            q0 <= q1;
            q1 <= mem_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters, one per line:
- SIZE, 32, address/instruction width.
- TIMEOUT, 16, ack-wait limit in cycles; used only with FETCH_TIMEOUT_EN.

REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  SIZE  current program counter value.
- pc_inc  out  1  post-increment strobe to the program counter.
- flush  in  1  branch/PC load this cycle; discard prefetched work.
- mem_req  out  1  memory read request, registered.
- mem_addr  out  SIZE  request address, registered.
- mem_ack  in  1  memory read complete; mem_data valid this cycle.
- mem_data  in  SIZE  read data.
- ir  out  SIZE  head instruction of the prefetch queue.
- ir_valid  out  1  ir holds a valid instruction.
- ir_ready  in  1  consumer accepts ir this cycle.
- fetch_err  out  1  sticky fetch timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY (request outstanding) and DRAIN (request outstanding whose data will be discarded).
REQ-004 SHALL hold a 2-entry FIFO prefetch queue; ir = head entry; ir_valid = (count != 0).
REQ-005 IDLE -> BUSY at a clock edge when count + 0 < 2, flush=0 and fetch_err=0; that edge sets mem_req=1 and latches mem_addr=pc.
REQ-006 While in BUSY or DRAIN, mem_req SHALL stay 1 and mem_addr SHALL stay stable until mem_ack is sampled high.
REQ-007 In BUSY with mem_ack=1 and flush=0, the block SHALL:
- push mem_data into the queue;
- assert pc_inc combinationally, so the PC increments on that same edge;
- clear mem_req and go to IDLE.
REQ-008 pc_inc SHALL be asserted only in the REQ-007 case; it is never asserted for more than one cycle per fetch.
REQ-009 Minimum issue spacing SHALL be one IDLE cycle between fetches, so the new pc is sampled.
REQ-010 A pop SHALL occur when ir_valid && ir_ready. Simultaneous push and pop:
- count unchanged;
- FIFO order preserved;
- push into a full queue is impossible, per REQ-005.
REQ-011 flush=1 SHALL clear the queue (count=0) on that edge; flush overrides pop.
REQ-012 flush in IDLE SHALL suppress issue that cycle.
REQ-013 flush in BUSY with mem_ack=0 SHALL move the FSM to DRAIN.
REQ-014 flush in BUSY with mem_ack=1 SHALL discard the data, give no pc_inc, and go to IDLE.
REQ-015 In DRAIN, mem_ack SHALL discard the data, give no pc_inc, clear mem_req and go to IDLE. A flush arriving in DRAIN keeps the FSM in DRAIN.
REQ-016 mem_ack SHALL be ignored in IDLE.

Reset
REQ-017 rst high SHALL immediately and asynchronously set:
- state=IDLE, count=0, all queue entries=0;
- mem_req=0, mem_addr=0, fetch_err=0, timeout counter=0.
Outputs follow: ir=0, ir_valid=0, pc_inc=0.
REQ-018 A reset mid-request SHALL abandon the request; a late mem_ack after release is ignored, per REQ-016.
REQ-019 First issue SHALL occur at the first clk edge after rst deasserts.

Configuration
REQ-020 Macro FETCH_TIMEOUT_EN, when defined, SHALL add a counter that:
- counts consecutive BUSY/DRAIN cycles with mem_ack=0;
- on reaching TIMEOUT, sets fetch_err=1, clears mem_req, goes to IDLE and gives no pc_inc.
fetch_err SHALL block issue until flush or rst clears it. The counter resets on every ack and on every issue.
REQ-021 Without FETCH_TIMEOUT_EN, fetch_err SHALL be constant 0, no counter logic shall exist, and requests wait indefinitely.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Basic fetch: pc=0x100, ack 2 cycles after mem_req with mem_data=0xDEADBEEF, ir_ready=0 -> mem_addr=0x100, one pc_inc pulse, ir=0xDEADBEEF, ir_valid=1.
- Fill: ir_ready=0, immediate acks -> exactly 2 fetches (pc 0x0, 0x1); mem_req stays 0 afterward with count=2.
- Flush during BUSY: flush one cycle after issue, ack 3 cycles later -> DRAIN, data discarded, no pc_inc, ir_valid=0, next mem_addr=new pc.
- Push+pop: count=1, ir_ready=1 on the ack edge -> count stays 1; the new head is the newly fetched word.
- Reset mid-request: rst pulse while mem_req=1 -> all outputs 0 immediately; ack arriving after release has no effect.
- FETCH_TIMEOUT_EN, TIMEOUT=16, no ack -> fetch_err=1 at cycle 16 after issue, mem_req=0, no further issue until flush, then the fetch resumes.
